// File: rtl/mux_scan_sel.sv
// Registered N-channel data mux with manual select and round-robin scan modes.
// Optional even-parity output on dout is enabled by defining MUX_PARITY_EN.
module mux_scan_sel #(
    parameter int CH_NUM = 4,
    parameter int DW     = 8,
    parameter int SEL_W  = 2,
    parameter int DWELL  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CH_NUM*DW-1:0] din,
    input  logic [SEL_W-1:0]     sel,
    input  logic                 mode,
    input  logic                 hold,
    output logic [DW-1:0]        dout,
    output logic [SEL_W-1:0]     ch,
    output logic                 dout_vld
`ifdef MUX_PARITY_EN
    ,
    output logic                 par
`endif
);

    localparam int CNT_W = $clog2(DWELL) + 1;
    localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(CH_NUM - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL - 1);

    typedef enum logic [1:0] {IDLE, MANUAL, SCAN} state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [SEL_W-1:0]   ch_n, sel_c;
    logic [DW-1:0]      dout_n;

    function automatic logic [DW-1:0] pick(input logic [CH_NUM*DW-1:0] bus,
                                           input logic [SEL_W-1:0] idx);
        pick = '0;
        for (int k = 0; k < CH_NUM; k++) begin
            if (int'(idx) == k) pick = bus[k*DW +: DW];
        end
    endfunction

    // Out-of-range selects saturate to the highest channel.
    always_comb begin
        sel_c = (int'(sel) >= CH_NUM) ? LAST_CH : sel;
    end

    always_comb begin
        state_n = state;
        ch_n    = ch;
        cnt_n   = cnt;
        if (!hold) begin
            case (state)
                IDLE: begin
                    cnt_n = '0;
                    if (mode) begin
                        state_n = SCAN;
                    end else begin
                        state_n = MANUAL;
                        ch_n    = sel_c;
                    end
                end
                MANUAL: begin
                    cnt_n = '0;
                    if (mode) state_n = SCAN;
                    else      ch_n    = sel_c;
                end
                SCAN: begin
                    if (!mode) begin
                        state_n = MANUAL;
                        cnt_n   = '0;
                        ch_n    = sel_c;
                    end else if (cnt == LAST_CNT) begin
                        cnt_n = '0;
                        ch_n  = (ch == LAST_CH) ? '0 : ch + SEL_W'(1);
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
                default: state_n = IDLE;
            endcase
        end
        // Data follows the channel being registered so dout and ch never disagree.
        dout_n = hold ? dout : pick(din, ch_n);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ch    <= '0;
            cnt   <= '0;
            dout  <= '0;
        end else begin
            state <= state_n;
            ch    <= ch_n;
            cnt   <= cnt_n;
            dout  <= dout_n;
        end
    end

`ifdef MUX_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) par <= 1'b0;
        else     par <= ^dout_n;
    end
`endif

    assign dout_vld = (state != IDLE);

endmodule

// File: tb/tb_mux_scan_sel.sv
// Self-checking bench for mux_scan_sel: directed scenarios then random traffic,
// compared each cycle against a channel/age reference model.
module tb_mux_scan_sel;

    localparam int CH_NUM = 4;
    localparam int DW     = 8;
    localparam int SEL_W  = 3;
    localparam int DWELL  = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [CH_NUM*DW-1:0] din;
    logic [SEL_W-1:0]     sel;
    logic                 mode;
    logic                 hold;
    logic [DW-1:0]        dout;
    logic [SEL_W-1:0]     ch;
    logic                 dout_vld;
`ifdef MUX_PARITY_EN
    logic                 par;
`endif

    int checks = 0;
    int errors = 0;

    bit            m_live;
    bit            m_scan;
    int            m_ch;
    int            m_age;
    logic [DW-1:0] m_dout;

    always #5 clk = ~clk;

    mux_scan_sel #(.CH_NUM(CH_NUM), .DW(DW), .SEL_W(SEL_W), .DWELL(DWELL)) dut (
        .clk      (clk),
        .rst      (rst),
        .din      (din),
        .sel      (sel),
        .mode     (mode),
        .hold     (hold),
        .dout     (dout),
        .ch       (ch),
        .dout_vld (dout_vld)
`ifdef MUX_PARITY_EN
        ,
        .par      (par)
`endif
    );

    function automatic int clampSel(input logic [SEL_W-1:0] s);
        return (int'(s) >= CH_NUM) ? CH_NUM - 1 : int'(s);
    endfunction

    function automatic logic [DW-1:0] chanOf(input int k);
        return din[k*DW +: DW];
    endfunction

    // Reference: a live flag, whether we scan, the channel and how long it has been shown.
    task automatic modelEdge();
        if (rst) begin
            m_live = 0; m_scan = 0; m_ch = 0; m_age = 0; m_dout = '0;
        end else if (!hold) begin
            if (!m_live) begin
                m_live = 1;
                m_scan = mode;
                m_age  = 0;
                if (!mode) m_ch = clampSel(sel);
            end else if (!mode) begin
                m_scan = 0;
                m_age  = 0;
                m_ch   = clampSel(sel);
            end else if (!m_scan) begin
                m_scan = 1;
                m_age  = 0;
            end else begin
                m_age++;
                if (m_age == DWELL) begin
                    m_age = 0;
                    m_ch  = (m_ch + 1) % CH_NUM;
                end
            end
            m_dout = chanOf(m_ch);
        end
    endtask

    task automatic checkOutput(input string tag);
        checks++;
        assert (dout === m_dout) else begin
            errors++;
            $error("FAIL %s dout: observed %0h expected %0h", tag, dout, m_dout);
        end
        checks++;
        assert (ch === SEL_W'(m_ch)) else begin
            errors++;
            $error("FAIL %s ch: observed %0d expected %0d", tag, ch, m_ch);
        end
        checks++;
        assert (dout_vld === m_live) else begin
            errors++;
            $error("FAIL %s vld: observed %0b expected %0b", tag, dout_vld, m_live);
        end
`ifdef MUX_PARITY_EN
        checks++;
        assert (par === ^m_dout) else begin
            errors++;
            $error("FAIL %s par: observed %0b expected %0b", tag, par, ^m_dout);
        end
`endif
    endtask

    task automatic checkConst(input string tag, input logic [DW-1:0] obs,
                              input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive inputs on the falling edge, model the rising edge, check on the next fall.
    task automatic applyStimulus(input logic r, input logic h, input logic m,
                                 input logic [SEL_W-1:0] s, input string tag);
        rst = r; hold = h; mode = m; sel = s;
        @(posedge clk);
        modelEdge();
        @(negedge clk);
        checkOutput(tag);
    endtask

    initial begin
        logic rm;
        rst = 1'b1; hold = 1'b0; mode = 1'b0; sel = '0;
        din = {8'h44, 8'h33, 8'h22, 8'h11};
        m_live = 0; m_scan = 0; m_ch = 0; m_age = 0; m_dout = '0;
        @(negedge clk);

        applyStimulus(1, 0, 0, 0, "reset0");
        applyStimulus(1, 0, 0, 0, "reset1");
        checkConst("reset_dout", dout, 8'h00);
        rst = 1'b0;
        #1;
        checks++;
        assert (dout_vld === 1'b0) else begin
            errors++;
            $error("FAIL idle_vld: observed %0b expected 0", dout_vld);
        end

        applyStimulus(0, 0, 0, 2, "man_sel2");
        checkConst("man_sel2_dout", dout, 8'h33);
        applyStimulus(0, 0, 0, 3, "man_sel3");
        checkConst("man_sel3_dout", dout, 8'h44);
        applyStimulus(0, 0, 0, 6, "man_clamp");
        applyStimulus(0, 0, 0, 0, "man_sel0");

        for (int i = 0; i < 17; i++) applyStimulus(0, 0, 1, 0, "scan");
        checkConst("scan_wrap_dout", dout, 8'h11);
        for (int i = 0; i < 6; i++) applyStimulus(0, 0, 1, 0, "scan_to_ch1");
        for (int i = 0; i < 5; i++) applyStimulus(0, 1, 1, 0, "hold");
        checkConst("hold_dout", dout, 8'h22);
        applyStimulus(0, 0, 1, 0, "resume1");
        applyStimulus(0, 0, 1, 0, "resume2");
        checkConst("resume_ch", 8'(ch), 8'd2);

        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 0, "scan_to_ch3");
        applyStimulus(1, 0, 1, 0, "rst_mid_scan");
        applyStimulus(0, 0, 1, 0, "scan_restart");
        applyStimulus(0, 1, 0, 2, "hold_mode_change");
        applyStimulus(0, 0, 0, 2, "mode_after_hold");

        din[7:0] = 8'h07;
        applyStimulus(0, 0, 0, 0, "par_07");
        checkConst("par_07_dout", dout, 8'h07);
        din[7:0] = 8'h03;
        applyStimulus(0, 0, 0, 0, "par_03");

        rm = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) rm = ~rm;
            if ($urandom_range(0, 3) == 0) din = $urandom;
            applyStimulus($urandom_range(0, 49) == 0, $urandom_range(0, 5) == 0, rm,
                          SEL_W'($urandom_range(0, 7)), "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
